// File: rtl/dram_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : dram_boot_loader
// Function : Packs a big-endian byte stream into 16-bit DRAM words and holds
//            the CVP14 in reset until the image is loaded. Define CHECKSUM_EN
//            to require a trailing 16-bit checksum before release.
// Revision : 1.0
// ============================================================================
module dram_boot_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] MAX_WORDS = 16'd4096
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  InByte,
    input  logic        InValid,
    output logic        InReady,
    output logic [15:0] Addr,
    output logic [15:0] MemData,
    output logic        WR,
    output logic        RD,
    output logic        CpuReset,
    output logic        Done,
    output logic        Error
);

    localparam logic [3:0] S_CNT_HI  = 4'd0;
    localparam logic [3:0] S_CNT_LO  = 4'd1;
    localparam logic [3:0] S_DATA_HI = 4'd2;
    localparam logic [3:0] S_DATA_LO = 4'd3;
    localparam logic [3:0] S_WRITE   = 4'd4;
    localparam logic [3:0] S_DONE    = 4'd5;
    localparam logic [3:0] S_ERROR   = 4'd6;
`ifdef CHECKSUM_EN
    localparam logic [3:0] S_CSUM_HI = 4'd7;
    localparam logic [3:0] S_CSUM_LO = 4'd8;
    localparam logic [3:0] S_CHECK   = 4'd9;
    localparam logic [3:0] S_TAIL    = S_CSUM_HI;
`else
    localparam logic [3:0] S_TAIL    = S_DONE;
`endif

    logic [3:0]  state_q, state_d;
    logic [15:0] count_q, idx_q;
    logic [7:0]  hi_q;
    logic        ready_q, wr_q;
    logic [15:0] addr_q, data_q;
`ifdef CHECKSUM_EN
    logic [15:0] sum_q, csum_q;
`endif

    logic        w_xfer, w_ready_d, w_last;
    logic [15:0] w_cnt_new;

    assign w_xfer    = InValid & ready_q;
    assign w_cnt_new = {count_q[15:8], InByte};
    assign w_last    = (idx_q + 16'd1) == count_q;

    // InReady is registered from the next state so the first cycle after reset reads 0.
    assign w_ready_d = (state_d == S_CNT_HI) || (state_d == S_CNT_LO) ||
`ifdef CHECKSUM_EN
                       (state_d == S_CSUM_HI) || (state_d == S_CSUM_LO) ||
`endif
                       (state_d == S_DATA_HI) || (state_d == S_DATA_LO);

    always_ff @(posedge Clk1) begin
        if (!Reset) begin
            state_q <= S_CNT_HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CNT_HI:  if (w_xfer) state_d = S_CNT_LO;
            S_CNT_LO: begin
                if (w_xfer) begin
                    if (w_cnt_new > MAX_WORDS)     state_d = S_ERROR;
                    else if (w_cnt_new == 16'd0)   state_d = S_TAIL;
                    else                           state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: if (w_xfer) state_d = S_DATA_LO;
            S_DATA_LO: if (w_xfer) state_d = S_WRITE;
            S_WRITE:   state_d = w_last ? S_TAIL : S_DATA_HI;
`ifdef CHECKSUM_EN
            S_CSUM_HI: if (w_xfer) state_d = S_CSUM_LO;
            S_CSUM_LO: if (w_xfer) state_d = S_CHECK;
            S_CHECK:   state_d = (csum_q == sum_q) ? S_DONE : S_ERROR;
`endif
            S_DONE,
            S_ERROR:   if (Start) state_d = S_CNT_HI;
            default:   state_d = S_ERROR;
        endcase
    end

    always_comb begin
        InReady  = ready_q;
        WR       = wr_q;
        Addr     = addr_q;
        MemData  = data_q;
        RD       = 1'b0;
        Done     = (state_q == S_DONE);
        Error    = (state_q == S_ERROR);
        CpuReset = (state_q != S_DONE);
    end

    always_ff @(posedge Clk1) begin
        if (!Reset) begin
            count_q <= 16'd0;
            idx_q   <= 16'd0;
            hi_q    <= 8'd0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            data_q  <= 16'd0;
`ifdef CHECKSUM_EN
            sum_q   <= 16'd0;
            csum_q  <= 16'd0;
`endif
        end else begin
            ready_q <= w_ready_d;
            wr_q    <= 1'b0;
            if (w_xfer) begin
                case (state_q)
                    S_CNT_HI:  count_q[15:8] <= InByte;
                    S_CNT_LO:  count_q[7:0]  <= InByte;
                    S_DATA_HI: hi_q          <= InByte;
                    S_DATA_LO: begin
                        wr_q   <= 1'b1;
                        addr_q <= BASE_ADDR + idx_q;
                        data_q <= {hi_q, InByte};
                    end
`ifdef CHECKSUM_EN
                    S_CSUM_HI: csum_q[15:8] <= InByte;
                    S_CSUM_LO: csum_q[7:0]  <= InByte;
`endif
                    default: ;
                endcase
            end
            if (state_q == S_WRITE) begin
                idx_q <= idx_q + 16'd1;
`ifdef CHECKSUM_EN
                sum_q <= sum_q + data_q;
`endif
            end
            if (((state_q == S_DONE) || (state_q == S_ERROR)) && Start) begin
                idx_q <= 16'd0;
`ifdef CHECKSUM_EN
                sum_q <= 16'd0;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dram_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_boot_loader
// Function : Vector table of load images plus hand sequences for reset and
//            restart; DRAM writes are matched against a scoreboard queue.
// Revision : 1.0
// ============================================================================
module tb_dram_boot_loader;

    localparam logic [15:0] BASE = 16'hFFFF;
    localparam logic [15:0] MAXW = 16'd4096;
    localparam int          NVEC = 5;
    localparam logic [3:0]  NO_STALL = 4'd15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_byte = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready, wr, rd, cpu_rst, done, err;
    logic [15:0] addr, mem_data;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];

    typedef struct packed {
        logic [3:0]       nbytes;
        logic [0:9][7:0]  bytes;
        logic [3:0]       stall_at;
        logic             exp_done;
    } vec_t;

    vec_t vecs [NVEC];

    dram_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .Clk1(clk), .Reset(rst_n), .Start(start), .InByte(in_byte), .InValid(in_valid),
        .InReady(in_ready), .Addr(addr), .MemData(mem_data), .WR(wr), .RD(rd),
        .CpuReset(cpu_rst), .Done(done), .Error(err)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Every WR cycle must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (wr === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wr: addr %0h data %0h with no write expected", addr, mem_data);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                check("wr_addr", {16'd0, addr}, {16'd0, e[31:16]});
                check("wr_data", {16'd0, mem_data}, {16'd0, e[15:0]});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: InReady stayed %b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || err) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL end_timeout: Done=%b Error=%b, required one of them 1", done, err);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
`ifdef CHECKSUM_EN
        vecs[0] = '{4'd8,  80'h0002_1234_ABCD_BE01_0000, NO_STALL, 1'b1};
        vecs[1] = '{4'd8,  80'h0002_1234_ABCD_BE01_0000, 4'd3,     1'b1};
        vecs[2] = '{4'd2,  80'h1001_0000_0000_0000_0000, NO_STALL, 1'b0};
        vecs[3] = '{4'd4,  80'h0000_0000_0000_0000_0000, NO_STALL, 1'b1};
        vecs[4] = '{4'd6,  80'h0001_0005_0006_0000_0000, NO_STALL, 1'b0};
`else
        vecs[0] = '{4'd6,  80'h0002_1234_ABCD_0000_0000, NO_STALL, 1'b1};
        vecs[1] = '{4'd6,  80'h0002_1234_ABCD_0000_0000, 4'd3,     1'b1};
        vecs[2] = '{4'd2,  80'h1001_0000_0000_0000_0000, NO_STALL, 1'b0};
        vecs[3] = '{4'd2,  80'h0000_0000_0000_0000_0000, NO_STALL, 1'b1};
        vecs[4] = '{4'd8,  80'h0003_0102_F00D_8000_0000, 4'd2,     1'b1};
`endif

        // Reset held for two edges
        repeat (2) @(negedge clk);
        check("rst_inready", {31'd0, in_ready}, 32'd0);
        check("rst_wr", {31'd0, wr}, 32'd0);
        check("rst_rd", {31'd0, rd}, 32'd0);
        check("rst_cpurst", {31'd0, cpu_rst}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, err}, 32'd0);
        check("rst_addr", {16'd0, addr}, {16'd0, BASE});
        check("rst_memdata", {16'd0, mem_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_inready", {31'd0, in_ready}, 32'd1);

        for (int v = 0; v < NVEC; v++) begin
            logic [15:0] n;
            n = {vecs[v].bytes[0], vecs[v].bytes[1]};
            for (int i = 0; i < int'(vecs[v].nbytes); i++) begin
                if (i == int'(vecs[v].stall_at)) repeat (5) @(negedge clk);
                if (i >= 3 && (i % 2) == 1 && ((i - 3) / 2) < int'(n) && n <= MAXW)
                    sb.push_back({BASE + 16'((i - 3) / 2), vecs[v].bytes[i-1], vecs[v].bytes[i]});
                send_byte(vecs[v].bytes[i]);
            end
            wait_end();
            check($sformatf("v%0d_done", v), {31'd0, done}, {31'd0, vecs[v].exp_done});
            check($sformatf("v%0d_error", v), {31'd0, err}, {31'd0, !vecs[v].exp_done});
            check($sformatf("v%0d_cpurst", v), {31'd0, cpu_rst}, {31'd0, !vecs[v].exp_done});
            check($sformatf("v%0d_inready", v), {31'd0, in_ready}, 32'd0);
            check($sformatf("v%0d_pending_wr", v), sb.size(), 32'd0);
            sb.delete();
            pulse_start();
            check($sformatf("v%0d_restart_inready", v), {31'd0, in_ready}, 32'd1);
            check($sformatf("v%0d_restart_flags", v), {29'd0, done, err, cpu_rst}, 32'd1);
        end

        // Ignored Start mid-load, then reset on the edge that would take the second lo byte
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        pulse_start();
        check("start_ignored", {29'd0, done, err, in_ready}, 32'd1);
        sb.push_back({BASE, 16'h1234});
        send_byte(8'h34);
        send_byte(8'hAB);
        in_valid = 1'b1;
        in_byte  = 8'hCD;
        rst_n    = 1'b0;
        @(negedge clk);
        check("midrst_wr", {31'd0, wr}, 32'd0);
        check("midrst_cpurst", {31'd0, cpu_rst}, 32'd1);
        check("midrst_inready", {31'd0, in_ready}, 32'd0);
        check("midrst_addr", {16'd0, addr}, {16'd0, BASE});
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef CHECKSUM_EN
        send_byte(8'h00);
        send_byte(8'h00);
`endif
        wait_end();
        check("empty_done", {30'd0, done, err}, 32'd2);
        check("empty_cpurst", {31'd0, cpu_rst}, 32'd0);
        check("empty_pending_wr", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
